// File: rtl/exc_seq.sv
// Exception/interrupt sequencer: picks one MEM-stage event per commit, strobes the CP0 updates,
// holds a multi-cycle pipeline flush and then redirects the PC to the vector or to EPC.
module exc_seq #(
   parameter logic [31:0] VECTOR       = 32'hBFC00380,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_pc,
   input  logic        i_mem_bd,
   input  logic        i_mem_exc,
   input  logic [4:0]  i_mem_code,
   input  logic [31:0] i_mem_badv,
   input  logic        i_mem_eret,
   input  logic        i_status_ie,
   input  logic        i_status_exl,
   input  logic [7:0]  i_status_im,
   input  logic [7:0]  i_cause_ip,
   input  logic [31:0] i_epc_in,
   output logic        o_busy,
   output logic        o_flush,
   output logic        o_exc_commit,
   output logic [4:0]  o_exc_code,
   output logic        o_exc_bd,
   output logic [31:0] o_exc_epc,
   output logic        o_badv_we,
   output logic [31:0] o_badv,
   output logic        o_eret_commit,
   output logic        o_redirect,
   output logic [31:0] o_redirect_pc
);

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned CODE_W = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_FLUSH = 2'd2,
      S_REDIR = 2'd3
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;

   // Event record captured in IDLE; replayed from HOLD and used for the redirect target.
   logic               r_rec_eret;
   logic [CODE_W-1:0]  r_rec_code;
   logic               r_rec_bd;
   logic [XLEN-1:0]    r_rec_epc;
   logic               r_rec_badv_we;
   logic [XLEN-1:0]    r_rec_badv;
   logic [XLEN-1:0]    r_rec_target;

   logic               r_busy;
   logic               r_flush;
   logic               r_exc_commit;
   logic [CODE_W-1:0]  r_exc_code;
   logic               r_exc_bd;
   logic [XLEN-1:0]    r_exc_epc;
   logic               r_badv_we;
   logic [XLEN-1:0]    r_badv;
   logic               r_eret_commit;
   logic               r_redirect;
   logic [XLEN-1:0]    r_redirect_pc;

   logic               w_int_req;
   logic               w_exc_ev;
   logic               w_eret_ev;
   logic               w_event;
   logic [CODE_W-1:0]  w_live_code;
   logic [XLEN-1:0]    w_live_epc;
   logic               w_live_badv_we;
   logic [XLEN-1:0]    w_live_target;

   logic               w_hold;
   logic               w_sel_eret;
   logic [CODE_W-1:0]  w_sel_code;
   logic               w_sel_bd;
   logic [XLEN-1:0]    w_sel_epc;
   logic               w_sel_badv_we;
   logic [XLEN-1:0]    w_sel_badv;
   logic               w_go;

   // Priority: interrupt, then exception (blocked by EXL), then ERET.
   assign w_int_req = i_status_ie & ~i_status_exl & (|(i_status_im & i_cause_ip)) & i_mem_valid;
   assign w_exc_ev  = i_mem_exc & i_mem_valid & ~i_status_exl & ~w_int_req;
   assign w_eret_ev = i_mem_eret & i_mem_valid & ~w_int_req & ~w_exc_ev;
   assign w_event   = w_int_req | w_exc_ev | w_eret_ev;

   assign w_live_code    = w_int_req ? CODE_W'(0) : i_mem_code;
   assign w_live_epc     = i_mem_bd ? (i_mem_pc - XLEN'(4)) : i_mem_pc;
   assign w_live_badv_we = w_exc_ev & ((i_mem_code == CODE_W'(4)) | (i_mem_code == CODE_W'(5)));
   assign w_live_target  = w_eret_ev ? i_epc_in : VECTOR;

   // A commit out of HOLD replays the latched record instead of the live MEM inputs.
   assign w_hold        = (r_state == S_HOLD);
   assign w_sel_eret    = w_hold ? r_rec_eret    : w_eret_ev;
   assign w_sel_code    = w_hold ? r_rec_code    : w_live_code;
   assign w_sel_bd      = w_hold ? r_rec_bd      : i_mem_bd;
   assign w_sel_epc     = w_hold ? r_rec_epc     : w_live_epc;
   assign w_sel_badv_we = w_hold ? r_rec_badv_we : w_live_badv_we;
   assign w_sel_badv    = w_hold ? r_rec_badv    : i_mem_badv;
   assign w_go          = ~i_stall & (((r_state == S_IDLE) & w_event) | w_hold);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_rec_eret    <= 1'b0;
         r_rec_code    <= '0;
         r_rec_bd      <= 1'b0;
         r_rec_epc     <= '0;
         r_rec_badv_we <= 1'b0;
         r_rec_badv    <= '0;
         r_rec_target  <= '0;
         r_busy        <= 1'b0;
         r_flush       <= 1'b0;
         r_exc_commit  <= 1'b0;
         r_exc_code    <= '0;
         r_exc_bd      <= 1'b0;
         r_exc_epc     <= '0;
         r_badv_we     <= 1'b0;
         r_badv        <= '0;
         r_eret_commit <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         r_exc_commit  <= 1'b0;
         r_eret_commit <= 1'b0;
         r_badv_we     <= 1'b0;
         r_redirect    <= 1'b0;

         if ((r_state == S_IDLE) && w_event) begin
            r_rec_eret    <= w_eret_ev;
            r_rec_code    <= w_live_code;
            r_rec_bd      <= i_mem_bd;
            r_rec_epc     <= w_live_epc;
            r_rec_badv_we <= w_live_badv_we;
            r_rec_badv    <= i_mem_badv;
            r_rec_target  <= w_live_target;
         end

         if (w_go) begin
            r_state <= S_FLUSH;
            r_cnt   <= CNT_W'(FLUSH_CYCLES);
            r_busy  <= 1'b1;
            r_flush <= 1'b1;
            if (w_sel_eret) begin
               r_eret_commit <= 1'b1;
            end else begin
               r_exc_commit <= 1'b1;
               r_exc_code   <= w_sel_code;
               r_exc_bd     <= w_sel_bd;
               r_exc_epc    <= w_sel_epc;
               r_badv_we    <= w_sel_badv_we;
               if (w_sel_badv_we) begin
                  r_badv <= w_sel_badv;
               end
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_event) begin
                     r_state <= S_HOLD;
                     r_busy  <= 1'b1;
                  end
               end
               S_HOLD: begin
                  r_state <= S_HOLD;
               end
               S_FLUSH: begin
                  if (r_cnt == CNT_W'(1)) begin
                     r_state       <= S_REDIR;
                     r_flush       <= 1'b0;
                     r_redirect    <= 1'b1;
                     r_redirect_pc <= r_rec_target;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
               S_REDIR: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_flush <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_busy        = r_busy;
   assign o_flush       = r_flush;
   assign o_exc_commit  = r_exc_commit;
   assign o_exc_code    = r_exc_code;
   assign o_exc_bd      = r_exc_bd;
   assign o_exc_epc     = r_exc_epc;
   assign o_badv_we     = r_badv_we;
   assign o_badv        = r_badv;
   assign o_eret_commit = r_eret_commit;
   assign o_redirect    = r_redirect;
   assign o_redirect_pc = r_redirect_pc;

endmodule
